// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port unified-memory arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } arb_state_e;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_LDR  = 1'b1;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational two-way request picker: round-robin on last grant, or fixed port-0 priority.
module arb_rr_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    input  logic fixed_prio,
    output logic gnt_id,
    output logic any
);

    always_comb begin
        any = req0 | req1;
        if (req0 && req1) begin
            gnt_id = fixed_prio ? PORT_CORE : ~last_gnt;
        end else begin
            // With no request at all the id is ignored by the caller.
            gnt_id = req0 ? PORT_CORE : PORT_LDR;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the unified instruction/data memory between the core datapath and the loader port.
// One transaction at a time: IDLE -> ISSUE -> (WAIT) -> DONE, then a one-cycle ack.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned     CntW      = $clog2(RD_LAT + 1);
    localparam logic [CntW-1:0] WaitInit  = CntW'(RD_LAT - 1);
    localparam logic            FixedPrio = (FIXED_PRIO != 0);

    arb_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              last_gnt_q, last_gnt_d;
    logic              gnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    logic              pick_id, pick_any;
    logic              load, capture;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    arb_rr_pick u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_gnt   (last_gnt_q),
        .fixed_prio (FixedPrio),
        .gnt_id     (pick_id),
        .any        (pick_any)
    );

    always_comb begin
        sel_we    = (pick_id == PORT_LDR) ? we1    : we0;
        sel_addr  = (pick_id == PORT_LDR) ? addr1  : addr0;
        sel_wdata = (pick_id == PORT_LDR) ? wdata1 : wdata0;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_gnt_d = last_gnt_q;
        load       = 1'b0;
        capture    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    load    = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (we_q) begin
                    state_d = StDone;
                end else begin
                    state_d = StWait;
                    cnt_d   = WaitInit;
                end
            end
            StWait: begin
                // Read data is only valid on the final wait cycle.
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDone: begin
                last_gnt_d = gnt_q;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            last_gnt_q <= PORT_LDR;
            gnt_q      <= PORT_CORE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_gnt_q <= last_gnt_d;
            if (load) begin
                gnt_q   <= pick_id;
                we_q    <= sel_we;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
            if (capture) begin
                if (gnt_q == PORT_LDR) begin
                    rdata1_q <= mem_rdata;
                end else begin
                    rdata0_q <= mem_rdata;
                end
            end
        end
    end

    // Address/data/we hold their latched values; only mem_en marks a real access.
    assign mem_en    = (state_q == StIssue);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != StIdle);
    assign ack0      = (state_q == StDone) && (gnt_q == PORT_CORE);
    assign ack1      = (state_q == StDone) && (gnt_q == PORT_LDR);
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: three arbiters (RD_LAT 1/3/8, inst 1 fixed priority) with memory models.
module tb_mem_port_arbiter;

    localparam int N = 3;

    typedef struct {
        int          inst;
        int          port;
        bit          rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sbq[$];

    logic        req0 [N];
    logic        we0 [N];
    logic [31:0] addr0 [N];
    logic [31:0] wdata0 [N];
    logic        req1 [N];
    logic        we1 [N];
    logic [31:0] addr1 [N];
    logic [31:0] wdata1 [N];
    logic        ack0 [N];
    logic        ack1 [N];
    logic [31:0] rdata0 [N];
    logic [31:0] rdata1 [N];
    logic        busy [N];
    logic        mem_en [N];
    logic        mem_we [N];
    logic [31:0] mem_addr [N];
    logic [31:0] mem_wdata [N];
    logic [31:0] mem_rdata [N];
    logic        en_prev [N];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 3 : 8;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int unsigned Lat = (g == 0) ? 1 : (g == 1) ? 3 : 8;
        localparam int unsigned Fp  = (g == 1) ? 1 : 0;
        logic [31:0] mem [64];
        logic [31:0] rd_hold = 32'h0;
        int          rd_cnt = 0;

        initial begin
            for (int k = 0; k < 64; k++) mem[k] = 32'hC0DE_0000 + 32'(k);
            mem[4] = 32'hDEAD_BEEF;
        end

        // Read data valid only Lat cycles after the strobe; filler elsewhere.
        always @(posedge clk) begin
            if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
            if (mem_en[g]) begin
                if (mem_we[g]) begin
                    mem[mem_addr[g][7:2]] <= mem_wdata[g];
                end else begin
                    rd_hold <= mem[mem_addr[g][7:2]];
                    rd_cnt  <= Lat;
                end
            end
        end
        assign mem_rdata[g] = (rd_cnt == 1) ? rd_hold : (32'hBAD0_0000 | 32'(rd_cnt));

        mem_port_arbiter #(
            .ADDR_W     (32),
            .DATA_W     (32),
            .RD_LAT     (Lat),
            .FIXED_PRIO (Fp)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req0      (req0[g]),
            .we0       (we0[g]),
            .addr0     (addr0[g]),
            .wdata0    (wdata0[g]),
            .req1      (req1[g]),
            .we1       (we1[g]),
            .addr1     (addr1[g]),
            .wdata1    (wdata1[g]),
            .ack0      (ack0[g]),
            .rdata0    (rdata0[g]),
            .ack1      (ack1[g]),
            .rdata1    (rdata1[g]),
            .busy      (busy[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every ack and checks protocol invariants.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                en_prev[i] <= 1'b0;
            end else begin
                check("mem_en_back_to_back", 32'(mem_en[i] && en_prev[i]), 32'h0);
                check("dual_ack", 32'(ack0[i] && ack1[i]), 32'h0);
                en_prev[i] <= mem_en[i];
                if (ack0[i] || ack1[i]) begin
                    if (sbq.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_ack: inst %0d ack0=%0b ack1=%0b, expected none",
                                 i, ack0[i], ack1[i]);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        check("ack_inst", 32'(i), 32'(e.inst));
                        check("ack_port", 32'(ack1[i]), 32'(e.port));
                        if (e.cyc >= 0) check("ack_cycle", 32'(cyc), 32'(e.cyc));
                        if (e.rd) check("ack_rdata", (e.port == 1) ? rdata1[i] : rdata0[i], e.data);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acks(input int i, input int n, input string name);
        int seen = 0;
        int k = 0;
        while (seen < n && k < 200) begin
            @(negedge clk);
            k++;
            if (ack0[i] || ack1[i]) seen++;
        end
        check(name, 32'(seen), 32'(n));
    endtask

    // One isolated transaction; called just after a rising edge with the DUT idle.
    task automatic single(input int i, input int port, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd);
        int t;
        bit got;
        exp_t e;
        if (port == 0) begin
            req0[i] = 1'b1; we0[i] = we; addr0[i] = addr; wdata0[i] = wd;
        end else begin
            req1[i] = 1'b1; we1[i] = we; addr1[i] = addr; wdata1[i] = wd;
        end
        t = cyc;
        e = '{i, port, !we, exp_rd, we ? t + 2 : t + 2 + lat_of(i)};
        sbq.push_back(e);
        @(negedge clk);
        @(negedge clk);
        check("issue_mem_en", 32'(mem_en[i]), 32'h1);
        check("issue_mem_we", 32'(mem_we[i]), 32'(we));
        check("issue_mem_addr", mem_addr[i], addr);
        if (we) check("issue_mem_wdata", mem_wdata[i], wd);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            if ((port == 0) ? ack0[i] : ack1[i]) got = 1'b1;
            else @(negedge clk);
        end
        check("ack_seen", 32'(got), 32'h1);
        tick();
        req0[i] = 1'b0;
        req1[i] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   nack;
        for (int i = 0; i < N; i++) begin
            req0[i] = 1'b0; we0[i] = 1'b0; addr0[i] = '0; wdata0[i] = '0;
            req1[i] = 1'b0; we1[i] = 1'b0; addr1[i] = '0; wdata1[i] = '0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check("rst_busy", 32'(busy[i]), 32'h0);
            check("rst_ack", 32'({ack0[i], ack1[i]}), 32'h0);
            check("rst_mem_en", 32'(mem_en[i]), 32'h0);
            check("rst_mem_addr", mem_addr[i], 32'h0);
            check("rst_rdata", rdata0[i] | rdata1[i], 32'h0);
        end
        tick();
        reset = 1'b0;
        tick();

        // Single read, single write, then readback of the write.
        single(0, 0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);
        single(0, 1, 1'b1, 32'h20, 32'h1234_5678, 32'h0);
        single(0, 1, 1'b0, 32'h20, 32'h0, 32'h1234_5678);
        check("rdata0_held", rdata0[0], 32'hDEAD_BEEF);

        // Latency sweep over RD_LAT = 1, 3, 8.
        for (int i = 0; i < N; i++) single(i, 0, 1'b0, 32'h0C, 32'h0, 32'hC0DE_0003);

        // Reset during the wait phase of a read.
        check("pre_reset_rdata", rdata0[2], 32'hC0DE_0003);
        req0[2] = 1'b1; we0[2] = 1'b0; addr0[2] = 32'h08;
        repeat (4) @(negedge clk);
        check("mid_read_busy", 32'(busy[2]), 32'h1);
        check("mid_read_mem_en", 32'(mem_en[2]), 32'h0);
        reset = 1'b1;
        req0[2] = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy[2]), 32'h0);
        check("abort_ack", 32'({ack0[2], ack1[2]}), 32'h0);
        check("abort_mem_en", 32'(mem_en[2]), 32'h0);
        check("abort_rdata", rdata0[2] | rdata1[2], 32'h0);
        tick();
        reset = 1'b0;
        nack = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (ack0[2] || ack1[2]) nack++;
        end
        check("no_ack_after_abort", 32'(nack), 32'h0);
        tick();

        // Round-robin tie on instance 0: grant order 0,1,0,1.
        addr0[0] = 32'h04; addr1[0] = 32'h08; we0[0] = 1'b0; we1[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            e = '{0, k % 2, 1'b1, (k % 2 == 0) ? 32'hC0DE_0001 : 32'hC0DE_0002, -1};
            sbq.push_back(e);
        end
        req0[0] = 1'b1;
        req1[0] = 1'b1;
        wait_acks(0, 4, "rr_ack_count");
        tick();
        req0[0] = 1'b0;
        req1[0] = 1'b0;
        tick();

        // Fixed priority on instance 1: port 0 keeps winning until req0 drops.
        addr0[1] = 32'h04; addr1[1] = 32'h08; we0[1] = 1'b0; we1[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            e = '{1, (k == 3) ? 1 : 0, 1'b1, (k == 3) ? 32'hC0DE_0002 : 32'hC0DE_0001, -1};
            sbq.push_back(e);
        end
        req0[1] = 1'b1;
        req1[1] = 1'b1;
        wait_acks(1, 3, "fixed_port0_acks");
        tick();
        req0[1] = 1'b0;
        wait_acks(1, 1, "fixed_port1_ack");
        tick();
        req1[1] = 1'b0;
        repeat (3) tick();

        check("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
